// File: rtl/eight_bit_d_latch_if.sv
// Data/enable bus of the clocked eight-bit storage register.
// The master drives d/enable and observes q/qbar; the slave is the register itself.
interface eight_bit_d_latch_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] d;
  logic             enable;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;

  modport master (
    output d,
    output enable,
    input  q,
    input  qbar
  );

  modport slave (
    input  d,
    input  enable,
    output q,
    output qbar
  );
endinterface

// File: rtl/eight_bit_d_latch.sv
// WIDTH-bit edge-triggered storage register with load enable and synchronous reset.
// Each bit is an independent flop; qbar is decoded combinationally from the stored state only.
module eight_bit_d_latch #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               reset,
  eight_bit_d_latch_if.slave bus
);

  // One flop per bit so each output bit depends only on its own d bit and the shared controls.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic bit_reg;
      logic bit_next;

      // Priority: reset, then enable, otherwise hold.
      always_comb begin
        bit_next = bit_reg;
        if (reset) begin
          bit_next = 1'b0;
        end else if (bus.enable) begin
          bit_next = bus.d[gi];
        end
      end

      always_ff @(posedge clk) begin
        bit_reg <= bit_next;
      end

      assign bus.q[gi]    = bit_reg;
      assign bus.qbar[gi] = ~bit_reg;
    end
  endgenerate

endmodule

// File: tb/tb_eight_bit_d_latch.sv
// Self-checking bench for eight_bit_d_latch: vector table, hand-written corner
// sequences and a scrambled exhaustive sweep, all checked through a scoreboard queue.
module tb_eight_bit_d_latch;

  logic clk;
  logic reset;

  eight_bit_d_latch_if #(.WIDTH(8)) bus ();

  eight_bit_d_latch #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] d;
    logic [7:0] exp_q;
  } vec_t;

  vec_t       vecs[14];
  logic [7:0] sb_q[$];
  logic [7:0] model_q;
  int         n_checks;
  int         n_errors;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h, required 0x%02h", name, act, exp);
    end
  endtask

  // Pop the oldest expected value and compare q and qbar against it.
  task automatic check_out(input string name);
    logic [7:0] exp;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty, got q=0x%02h, required an entry", name, bus.q);
    end else begin
      exp = sb_q.pop_front();
      cmp({name, ".q"}, bus.q, exp);
      cmp({name, ".qbar"}, bus.qbar, ~exp);
    end
  endtask

  // Apply one set of inputs for exactly one rising edge, then check one step later.
  task automatic drive(input string name, input logic r, input logic e,
                       input logic [7:0] dv, input logic [7:0] exp, input bit verbose);
    @(negedge clk);
    reset      = r;
    bus.enable = e;
    bus.d      = dv;
    sb_q.push_back(exp);
    model_q = exp;
    @(posedge clk);
    #1;
    if (verbose)
      $display("txn %-10s reset=%0d enable=%0d d=0x%02h -> q=0x%02h qbar=0x%02h (exp q=0x%02h)",
               name, r, e, dv, bus.q, bus.qbar, exp);
    check_out(name);
  endtask

  function automatic logic [7:0] ref_next(input logic [7:0] cur, input logic r,
                                          input logic e, input logic [7:0] dv);
    if (r) return 8'h00;
    if (e) return dv;
    return cur;
  endfunction

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    model_q    = 8'h00;
    reset      = 1'b0;
    bus.enable = 1'b0;
    bus.d      = 8'h00;

    vecs[0]  = '{rst: 1'b1, en: 1'b1, d: 8'hA5, exp_q: 8'h00};
    vecs[1]  = '{rst: 1'b0, en: 1'b1, d: 8'h3C, exp_q: 8'h3C};
    vecs[2]  = '{rst: 1'b0, en: 1'b0, d: 8'hFF, exp_q: 8'h3C};
    vecs[3]  = '{rst: 1'b0, en: 1'b0, d: 8'hFF, exp_q: 8'h3C};
    vecs[4]  = '{rst: 1'b0, en: 1'b0, d: 8'hFF, exp_q: 8'h3C};
    vecs[5]  = '{rst: 1'b0, en: 1'b1, d: 8'h01, exp_q: 8'h01};
    vecs[6]  = '{rst: 1'b0, en: 1'b1, d: 8'h80, exp_q: 8'h80};
    vecs[7]  = '{rst: 1'b0, en: 1'b1, d: 8'hFF, exp_q: 8'hFF};
    vecs[8]  = '{rst: 1'b1, en: 1'b1, d: 8'h77, exp_q: 8'h00};
    vecs[9]  = '{rst: 1'b1, en: 1'b0, d: 8'h66, exp_q: 8'h00};
    vecs[10] = '{rst: 1'b1, en: 1'b1, d: 8'hFF, exp_q: 8'h00};
    vecs[11] = '{rst: 1'b0, en: 1'b1, d: 8'h42, exp_q: 8'h42};
    vecs[12] = '{rst: 1'b0, en: 1'b0, d: 8'h00, exp_q: 8'h42};
    vecs[13] = '{rst: 1'b0, en: 1'b1, d: 8'h3C, exp_q: 8'h3C};

    // Before any reset q is undefined, but qbar must still be its complement.
    #1;
    cmp("pre_reset.qbar", bus.qbar, ~bus.q);

    for (int i = 0; i < 14; i++) begin
      drive($sformatf("vec%0d", i), vecs[i].rst, vecs[i].en, vecs[i].d, vecs[i].exp_q, 1'b1);
    end

    // Reset pulsed entirely between edges must not disturb q.
    @(negedge clk);
    reset = 1'b1;
    #2;
    cmp("midpulse.q", bus.q, 8'h3C);
    reset = 1'b0;
    #1;
    cmp("postpulse.q", bus.q, 8'h3C);
    cmp("postpulse.qbar", bus.qbar, 8'hC3);
    $display("txn midpulse   reset pulsed between edges -> q=0x%02h (exp q=0x3c)", bus.q);
    drive("syncrst", 1'b1, 1'b0, 8'h5A, 8'h00, 1'b1);

    // d/enable wiggles between edges are ignored; only the values at the edge count.
    drive("load11", 1'b0, 1'b1, 8'h11, 8'h11, 1'b1);
    @(negedge clk);
    bus.enable = 1'b1;
    bus.d      = 8'hEE;
    #2;
    cmp("midwiggle.q", bus.q, 8'h11);
    bus.enable = 1'b0;
    bus.d      = 8'h00;
    sb_q.push_back(8'h11);
    @(posedge clk);
    #1;
    $display("txn wiggle     enable/d toggled mid-cycle, enable=0 at edge -> q=0x%02h (exp q=0x11)", bus.q);
    check_out("wiggle");

    // Exhaustive sweep in a scrambled order so every control combination follows varied states.
    for (int i = 0; i < 1024; i++) begin
      int         j;
      logic [9:0] idx;
      logic [7:0] exp;
      j   = (i * 389 + 17) % 1024;
      idx = j[9:0];
      exp = ref_next(model_q, idx[1], idx[0], idx[9:2]);
      drive($sformatf("sweep%0d", i), idx[1], idx[0], idx[9:2], exp, 1'b0);
    end
    $display("txn sweep      1024 combinations of d x enable x reset applied");

    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
